// File: rtl/myip_pwm_multi.sv
// myip_pwm_multi: NUM_CH PWM outputs behind an AXI4-Lite slave, sharing one
// prescaler and one period counter. PERIOD and DUTY are double-buffered.
// The shadow copies move to the active copies at a period boundary when
// UPD is pending. While EN=0 they move on every cycle.
//
// Ports
//   s00_axi_aclk / s00_axi_areset : clock, asynchronous active-high reset
//   s00_axi_aw*/w*/b*/ar*/r*      : AXI4-Lite slave (32-bit data, 64-byte window)
//   pwm_out[NUM_CH-1:0]           : registered PWM outputs
//   irq                           : one-clock pulse after each period boundary (IE=1)
//
// Register map: 0x00 CTRL {IE,UPD,CENTER,EN}, 0x04 PERIOD, 0x08 PRESCALE,
//               0x0C CH_EN, 0x10+4n DUTY[n]
//
// Counter direction (centre mode)
//   state    | meaning
//   DIR_UP   | counting 0 -> PERIOD (also used in edge mode)
//   DIR_DOWN | counting PERIOD-1 -> 0; the boundary is the tick at cnt==1

module myip_pwm_multi #(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 6,
  parameter int NUM_CH               = 4,
  parameter int CNT_WIDTH            = 16
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_areset,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic [NUM_CH-1:0]                 pwm_out,
  output logic                              irq
);

  localparam int IW = C_S00_AXI_ADDR_WIDTH - 2;
  localparam logic [IW-1:0] A_CTRL   = IW'(0);
  localparam logic [IW-1:0] A_PERIOD = IW'(1);
  localparam logic [IW-1:0] A_PRESC  = IW'(2);
  localparam logic [IW-1:0] A_CHEN   = IW'(3);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

  logic                 en_q, en_d, center_q, center_d, upd_q, upd_d, ie_q, ie_d;
  logic [CNT_WIDTH-1:0] period_sh_q, period_sh_d, period_act_q, period_act_d;
  logic [15:0]          prescale_q, prescale_d, presc_q, presc_d;
  logic [NUM_CH-1:0]    ch_en_q, ch_en_d, pwm_q, pwm_d;
  logic [CNT_WIDTH-1:0] duty_sh_q [NUM_CH];
  logic [CNT_WIDTH-1:0] duty_sh_d [NUM_CH];
  logic [CNT_WIDTH-1:0] duty_act_q [NUM_CH];
  logic [CNT_WIDTH-1:0] duty_act_d [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 center_act_q, center_act_d;
  dir_e                 dir_q, dir_d;
  logic                 irq_q, irq_d;
  logic                 awready_q, awready_d, bvalid_q, bvalid_d;
  logic                 arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0]          rdata_q, rdata_d, rd_val;
  logic [IW-1:0]        widx, ridx;
  logic                 wr_hs, rd_hs, tick, boundary;

  logic unused_ok;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // Byte-lane merge of a write into the current register value.
  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] wd,
                                        input logic [3:0]  st);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = st[b] ? wd[8*b +: 8] : old_v[8*b +: 8];
    return r;
  endfunction

  assign widx  = s00_axi_awaddr[C_S00_AXI_ADDR_WIDTH-1:2];
  assign ridx  = s00_axi_araddr[C_S00_AXI_ADDR_WIDTH-1:2];
  // Ready is only raised after both valids were seen, so a handshake cycle
  // is ready_q together with the still-held valids.
  assign wr_hs = awready_q & s00_axi_awvalid & s00_axi_wvalid;
  assign rd_hs = arready_q & s00_axi_arvalid;

  always_comb begin
    rd_val = '0;
    case (ridx)
      A_CTRL:   rd_val[3:0] = {ie_q, upd_q, center_q, en_q};
      A_PERIOD: rd_val = 32'(period_sh_q);
      A_PRESC:  rd_val[15:0] = prescale_q;
      A_CHEN:   rd_val[NUM_CH-1:0] = ch_en_q;
      default: begin
        for (int n = 0; n < NUM_CH; n++)
          if (ridx == IW'(n + 4)) rd_val = 32'(duty_sh_q[n]);
      end
    endcase
  end

  always_comb begin
    en_d         = en_q;
    center_d     = center_q;
    upd_d        = upd_q;
    ie_d         = ie_q;
    period_sh_d  = period_sh_q;
    prescale_d   = prescale_q;
    ch_en_d      = ch_en_q;
    duty_sh_d    = duty_sh_q;
    period_act_d = period_act_q;
    duty_act_d   = duty_act_q;
    center_act_d = center_act_q;
    dir_d        = dir_q;
    cnt_d        = cnt_q;
    presc_d      = presc_q;
    boundary     = 1'b0;
    tick         = en_q && (presc_q == prescale_q);

    // Counter / shadow transfer, using the register values before this write.
    if (!en_q) begin
      presc_d      = '0;
      cnt_d        = '0;
      dir_d        = DIR_UP;
      center_act_d = center_q;
      period_act_d = period_sh_q;
      duty_act_d   = duty_sh_q;
      upd_d        = 1'b0;
    end else begin
      presc_d = tick ? 16'd0 : presc_q + 16'd1;
      if (tick) begin
        if (!center_act_q) begin
          if (cnt_q == period_act_q) begin
            cnt_d    = '0;
            boundary = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else if (dir_q == DIR_UP) begin
          if (cnt_q != period_act_q) begin
            cnt_d = cnt_q + CNT_ONE;
          end else if (period_act_q <= CNT_ONE) begin
            // Peak of 0 or 1 is also the last down-count tick.
            cnt_d    = '0;
            boundary = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
            dir_d = DIR_DOWN;
          end
        end else begin
          if (cnt_q <= CNT_ONE) begin
            cnt_d    = '0;
            boundary = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      if (boundary) begin
        center_act_d = center_q;
        dir_d        = DIR_UP;
        if (upd_q) begin
          period_act_d = period_sh_q;
          duty_act_d   = duty_sh_q;
          upd_d        = 1'b0;
        end
      end
    end

    // Register writes; a UPD request set here survives a same-cycle boundary.
    if (wr_hs) begin
      case (widx)
        A_CTRL: begin
          if (s00_axi_wstrb[0]) begin
            en_d     = s00_axi_wdata[0];
            center_d = s00_axi_wdata[1];
            ie_d     = s00_axi_wdata[3];
            if (s00_axi_wdata[2]) upd_d = 1'b1;
          end
        end
        A_PERIOD: period_sh_d = CNT_WIDTH'(merge(32'(period_sh_q),
                                                 s00_axi_wdata, s00_axi_wstrb));
        A_PRESC:  prescale_d  = 16'(merge({16'd0, prescale_q},
                                          s00_axi_wdata, s00_axi_wstrb));
        A_CHEN:   if (s00_axi_wstrb[0]) ch_en_d = s00_axi_wdata[NUM_CH-1:0];
        default: begin
          for (int n = 0; n < NUM_CH; n++)
            if (widx == IW'(n + 4))
              duty_sh_d[n] = CNT_WIDTH'(merge(32'(duty_sh_q[n]),
                                              s00_axi_wdata, s00_axi_wstrb));
        end
      endcase
    end
  end

  always_comb begin
    for (int n = 0; n < NUM_CH; n++)
      pwm_d[n] = en_q & ch_en_q[n] & (cnt_q < duty_act_q[n]);
    irq_d     = boundary & ie_q;
    awready_d = !awready_q && s00_axi_awvalid && s00_axi_wvalid && !bvalid_q;
    bvalid_d  = wr_hs ? 1'b1 : (s00_axi_bready ? 1'b0 : bvalid_q);
    arready_d = !arready_q && s00_axi_arvalid && !rvalid_q;
    rvalid_d  = rd_hs ? 1'b1 : (s00_axi_rready ? 1'b0 : rvalid_q);
    rdata_d   = rd_hs ? rd_val : rdata_q;
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      en_q         <= 1'b0;
      center_q     <= 1'b0;
      upd_q        <= 1'b0;
      ie_q         <= 1'b0;
      period_sh_q  <= '0;
      prescale_q   <= '0;
      ch_en_q      <= '0;
      period_act_q <= '0;
      center_act_q <= 1'b0;
      dir_q        <= DIR_UP;
      cnt_q        <= '0;
      presc_q      <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        duty_sh_q[n]  <= '0;
        duty_act_q[n] <= '0;
      end
      pwm_q        <= '0;
      irq_q        <= 1'b0;
      awready_q    <= 1'b0;
      bvalid_q     <= 1'b0;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      en_q         <= en_d;
      center_q     <= center_d;
      upd_q        <= upd_d;
      ie_q         <= ie_d;
      period_sh_q  <= period_sh_d;
      prescale_q   <= prescale_d;
      ch_en_q      <= ch_en_d;
      period_act_q <= period_act_d;
      center_act_q <= center_act_d;
      dir_q        <= dir_d;
      cnt_q        <= cnt_d;
      presc_q      <= presc_d;
      duty_sh_q    <= duty_sh_d;
      duty_act_q   <= duty_act_d;
      pwm_q        <= pwm_d;
      irq_q        <= irq_d;
      awready_q    <= awready_d;
      bvalid_q     <= bvalid_d;
      arready_q    <= arready_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = awready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = 2'b00;
  assign pwm_out         = pwm_q;
  assign irq             = irq_q;

endmodule
